// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC slice XOR speculative global history indexes a table
// of saturating counters. Optional macro GSHARE_WR_BYPASS_EN forwards same-index training into pred.
`ifndef BRANCH_HISTORY_TABLE_SIZE
`define BRANCH_HISTORY_TABLE_SIZE 16
`endif

module gshare_predictor #(
    parameter int DEPTH     = `BRANCH_HISTORY_TABLE_SIZE,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = $clog2(DEPTH),
    parameter int PC_LSB    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rd_en,
    input  logic [31:0]                rd_pc,
    output logic                       pred,
    output logic [$clog2(DEPTH)-1:0]   out_index,
    output logic [HIST_BITS-1:0]       out_bhr,
    output logic [HIST_BITS-1:0]       bhr,
    input  logic                       wr_en,
    input  logic                       wr_taken,
    input  logic [$clog2(DEPTH)-1:0]   wr_index,
    input  logic                       recover_en,
    input  logic [HIST_BITS-1:0]       recover_bhr,
    input  logic                       recover_taken
);

    localparam int LOG_DEPTH = $clog2(DEPTH);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0]  ctr_reg  [DEPTH];
    logic [CTR_BITS-1:0]  ctr_next [DEPTH];
    logic [HIST_BITS-1:0] ghr_reg;
    logic [HIST_BITS-1:0] ghr_next;

    logic [CTR_BITS-1:0]  wr_cur;
    logic [CTR_BITS-1:0]  wr_next;
    logic [DEPTH-1:0]     wr_onehot;
    logic                 rd_msb;
    logic                 unused_pc;

    // Only the index slice of the PC matters; fold the rest away.
    assign unused_pc = ^rd_pc;

    assign out_index = rd_pc[PC_LSB +: LOG_DEPTH] ^ LOG_DEPTH'(ghr_reg);
    assign out_bhr   = ghr_reg;
    assign bhr       = ghr_reg;
    assign rd_msb    = ctr_reg[out_index][CTR_BITS-1];

    assign wr_cur = ctr_reg[wr_index];

    always_comb begin
        wr_next = wr_cur;
        if (wr_taken) begin
            if (wr_cur != CTR_MAX) wr_next = wr_cur + CTR_BITS'(1);
        end else begin
            if (wr_cur != '0) wr_next = wr_cur - CTR_BITS'(1);
        end
    end

`ifdef GSHARE_WR_BYPASS_EN
    // Forward the post-update counter when fetch reads the entry being trained.
    assign pred = (reset && wr_en && (wr_index == out_index)) ? wr_next[CTR_BITS-1] : rd_msb;
`else
    assign pred = rd_msb;
`endif

    assign wr_onehot = wr_en ? (DEPTH'(1) << wr_index) : '0;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ctr
        assign ctr_next[gi] = wr_onehot[gi] ? wr_next : ctr_reg[gi];
    end

    // Recovery replays the mispredicted branch on top of its checkpoint; it overrides any
    // speculative shift from a same-cycle read, which fetch discards anyway.
    always_comb begin
        ghr_next = ghr_reg;
        if (recover_en) begin
            ghr_next = (recover_bhr << 1) | HIST_BITS'(recover_taken);
        end else if (rd_en) begin
            ghr_next = (ghr_reg << 1) | HIST_BITS'(pred);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_reg[i] <= CTR_INIT;
            end
            ghr_reg <= '0;
        end else begin
            ctr_reg <= ctr_next;
            ghr_reg <= ghr_next;
        end
    end

endmodule
